// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier output path.
package booth_pkg;

    localparam int PROD_W = 16;
    localparam int BYTE_W = 8;

    // Which half of the head product is currently on the byte port.
    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    typedef logic signed [PROD_W-1:0] prod_t;

endpackage : booth_pkg

// File: rtl/booth_prod_fifo.sv
// Small register FIFO holding whole products; head entry is always visible on head.
module booth_prod_fifo #(
    parameter int PROD_W = 16,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [PROD_W-1:0] wdata,
    output logic [PROD_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic signed [PROD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is reset so the byte port reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : booth_prod_fifo

// File: rtl/booth_result_serializer.sv
// Buffers signed products from the Booth core and streams each one low byte first.
module booth_result_serializer #(
    parameter int PROD_W = 16,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_sel,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    import booth_pkg::*;

    if (PROD_W != 2 * BYTE_W) begin : g_bad_width
        $error("PROD_W must be exactly two bytes wide");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    phase_t              phase_q;
    phase_t              phase_d;
    logic                overflow_q;
    logic                push;
    logic                pop;
    logic                byte_xfer;
    logic                full;
    logic                empty;
    logic [PROD_W-1:0]   head;

    function automatic logic [BYTE_W-1:0] select_byte(
        input logic [PROD_W-1:0] prod,
        input phase_t            ph
    );
        return (ph == PH_HI) ? prod[PROD_W-1:BYTE_W] : prod[BYTE_W-1:0];
    endfunction

    // in_ready comes from the registered count, so a pop while full frees the slot one cycle later.
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign byte_xfer = out_valid & out_ack;
    assign pop       = byte_xfer & (phase_q == PH_HI);

    booth_prod_fifo #(
        .PROD_W (PROD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (in_product),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_LO;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = PH_LO;
        end else if (byte_xfer) begin
            phase_d = (phase_q == PH_LO) ? PH_HI : PH_LO;
        end
    end

    // Sticky record of any product the core offered while the buffer was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (clr) begin
            overflow_q <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
    assign out_sel  = phase_q;
    assign out_byte = select_byte(head, phase_q);

endmodule : booth_result_serializer

// File: tb/tb_booth_result_serializer.sv
// Scoreboard bench for booth_result_serializer: expected bytes queued on push, checked as presented.
module tb_booth_result_serializer;

    import booth_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_product = '0;
    logic        out_valid;
    logic        out_ack = 1'b0;
    logic [7:0]  out_byte;
    logic        out_sel;
    logic [1:0]  count;
    logic        overflow;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Each entry is {sel, byte} in the order the port must present them.
    logic [8:0]  exp_q [$];
    int          mdl_cnt = 0;
    logic        mdl_ovf = 1'b0;

    booth_result_serializer #(
        .PROD_W (16),
        .BYTE_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .out_byte   (out_byte),
        .out_sel    (out_sel),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] p, input logic ack);
        in_valid   = v;
        in_product = p;
        out_ack    = ack;
    endtask

    // Sample at the falling edge, update the model with what the next rising edge does.
    task automatic cycle();
        logic do_push;
        logic do_byte;
        logic do_pop;
        prod_t p;
        @(negedge clk);
        check_eq("in_ready", 32'(in_ready), 32'(mdl_cnt != DEPTH));
        check_eq("out_valid", 32'(out_valid), 32'(mdl_cnt != 0));
        check_eq("count", 32'(count), 32'(mdl_cnt));
        check_eq("overflow", 32'(overflow), 32'(mdl_ovf));
        if (mdl_cnt != 0 && exp_q.size() != 0) begin
            check_eq("out_byte", 32'(out_byte), 32'(exp_q[0][7:0]));
            check_eq("out_sel", 32'(out_sel), 32'(exp_q[0][8]));
        end
        do_push = in_valid && (mdl_cnt != DEPTH);
        do_byte = out_ack && (mdl_cnt != 0) && (exp_q.size() != 0);
        do_pop  = do_byte && exp_q[0][8];
        if (clr) begin
            exp_q.delete();
            mdl_cnt = 0;
            mdl_ovf = 1'b0;
        end else begin
            if (in_valid && mdl_cnt == DEPTH) mdl_ovf = 1'b1;
            if (do_byte) void'(exp_q.pop_front());
            if (do_push) begin
                p = prod_t'(in_product);
                exp_q.push_back({1'b0, p[7:0]});
                exp_q.push_back({1'b1, p[15:8]});
            end
            mdl_cnt = mdl_cnt + int'(do_push) - int'(do_pop);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_sel", 32'(out_sel), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_out_byte", 32'(out_byte), 32'd0);
        rst = 1'b0;
        cycle();

        // 0x1234 with ack held high
        drive(1'b1, 16'h1234, 1'b1);
        cycle();
        drive(1'b0, 16'h0000, 1'b1);
        repeat (3) cycle();
        check_eq("t1_count", 32'(count), 32'd0);

        // 0xFFF1 (-15) stalled by the consumer
        drive(1'b1, 16'hFFF1, 1'b0);
        cycle();
        drive(1'b0, 16'h0000, 1'b0);
        repeat (5) cycle();
        check_eq("t2_hold_byte", 32'(out_byte), 32'hF1);
        drive(1'b0, 16'h0000, 1'b1);
        repeat (3) cycle();

        // Fill, then a third product is dropped and flagged
        drive(1'b1, 16'h0001, 1'b0);
        cycle();
        drive(1'b1, 16'h8000, 1'b0);
        cycle();
        drive(1'b1, 16'h7FFF, 1'b0);
        cycle();
        drive(1'b0, 16'h0000, 1'b0);
        cycle();
        check_eq("t3_full_ready", 32'(in_ready), 32'd0);
        check_eq("t3_overflow", 32'(overflow), 32'd1);
        drive(1'b0, 16'h0000, 1'b1);
        repeat (5) cycle();
        check_eq("t3_sticky_ovf", 32'(overflow), 32'd1);

        // Push and pop on the same edge with one product held in PH_HI
        drive(1'b1, 16'h5A5A, 1'b1);
        cycle();
        drive(1'b0, 16'h0000, 1'b1);
        cycle();
        drive(1'b1, 16'hC3A7, 1'b1);
        cycle();
        drive(1'b0, 16'h0000, 1'b0);
        cycle();
        check_eq("t4_count", 32'(count), 32'd1);
        check_eq("t4_new_lo", 32'(out_byte), 32'hA7);
        drive(1'b0, 16'h0000, 1'b1);
        repeat (3) cycle();

        // Asynchronous reset mid-product with a full buffer
        drive(1'b1, 16'h1111, 1'b0);
        cycle();
        drive(1'b1, 16'h2222, 1'b0);
        cycle();
        drive(1'b0, 16'h0000, 1'b1);
        cycle();
        drive(1'b0, 16'h0000, 1'b0);
        check_eq("t5_pre_sel", 32'(out_sel), 32'd1);
        check_eq("t5_pre_count", 32'(count), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_count", 32'(count), 32'd0);
        check_eq("t5_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_in_ready", 32'(in_ready), 32'd1);
        check_eq("t5_out_sel", 32'(out_sel), 32'd0);
        check_eq("t5_overflow", 32'(overflow), 32'd0);
        check_eq("t5_out_byte", 32'(out_byte), 32'd0);
        exp_q.delete();
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 16'hABCD, 1'b1);
        cycle();
        drive(1'b0, 16'h0000, 1'b1);
        check_eq("t5_first_byte", 32'(out_byte), 32'hCD);
        repeat (3) cycle();

        // clr together with a push and an ack
        drive(1'b1, 16'h0102, 1'b0);
        cycle();
        drive(1'b1, 16'h0304, 1'b0);
        cycle();
        drive(1'b1, 16'h0506, 1'b1);
        cycle();
        drive(1'b1, 16'h4444, 1'b1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        check_eq("t6_count", 32'(count), 32'd0);
        check_eq("t6_overflow", 32'(overflow), 32'd0);
        check_eq("t6_out_valid", 32'(out_valid), 32'd0);
        cycle();
        drive(1'b1, 16'h9876, 1'b1);
        cycle();
        drive(1'b0, 16'h0000, 1'b1);
        check_eq("t6_restart_sel", 32'(out_sel), 32'd0);
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_booth_result_serializer
